// File: rtl/microsequencer_if.sv
// Bus between the microsequencer and the control store / datapath.
// master: the sequencer (drives the ROM address and status).
// slave : the surrounding controller (ROM fields, encoder, memory, flags).
interface microsequencer_if;
    logic       hold;
    logic [7:0] enc_state;
    logic [5:0] cr;
    logic [2:0] n;
    logic       inv;
    logic       moc;
    logic       cond;
    logic [7:0] state;
    logic       mem_abort;
    logic       bad_op;

    modport master (
        input  hold, enc_state, cr, n, inv, moc, cond,
        output state, mem_abort, bad_op
    );

    modport slave (
        output hold, enc_state, cr, n, inv, moc, cond,
        input  state, mem_abort, bad_op
    );
endinterface

// File: rtl/microsequencer.sv
// Next-state sequencer for the microprogrammed control unit. Each cycle
// it selects the next control-ROM address from the N2..N0 mode field. A
// wait counter bounds MOC waits so that a lost memory completion aborts
// to ABORT_STATE instead of hanging the controller.
module microsequencer #(
    parameter int unsigned TIMEOUT     = 16,
    parameter logic [7:0]  ABORT_STATE = 8'd63
) (
    input  logic              clk,
    input  logic              rst_n,
    microsequencer_if.master  bus
);

    typedef enum logic [2:0] {
        M_FETCH     = 3'b000,
        M_DISPATCH  = 3'b001,
        M_JUMP      = 3'b010,
        M_INC       = 3'b011,
        M_CDISPATCH = 3'b100,
        M_WAIT      = 3'b101,
        M_CJUMP     = 3'b110,
        M_RESERVED  = 3'b111
    } mode_t;

    localparam logic [7:0] LP_WAIT_LAST = 8'(TIMEOUT - 1);

    logic [7:0] r_state;
    logic [7:0] r_wait_cnt;
    logic       r_mem_abort;
    logic       r_bad_op;

    mode_t      w_mode;
    logic       w_t;
    logic       w_m;
    logic [7:0] w_inc;
    logic [7:0] w_cr_ext;
    logic [7:0] w_next_state;
    logic [7:0] w_next_cnt;
    logic       w_next_abort;
    logic       w_next_bad_op;

    assign w_mode   = mode_t'(bus.n);
    assign w_t      = bus.cond ^ bus.inv;
    assign w_m      = bus.moc ^ bus.inv;
    assign w_inc    = r_state + 8'd1;
    assign w_cr_ext = {2'b00, bus.cr};

    // Next address, wait-counter and status selection for the current microinstruction.
    always_comb begin
        w_next_state  = r_state;
        w_next_cnt    = '0;
        w_next_abort  = 1'b0;
        w_next_bad_op = r_bad_op;
        case (w_mode)
            M_FETCH:     w_next_state = '0;
            M_DISPATCH:  w_next_state = bus.enc_state;
            M_JUMP:      w_next_state = w_cr_ext;
            M_INC:       w_next_state = w_inc;
            M_CDISPATCH: w_next_state = w_t ? bus.enc_state : 8'd0;
            M_WAIT: begin
                // Completion is tested first so it wins over a same-cycle timeout.
                if (w_m) begin
                    w_next_state = w_inc;
                end else if (r_wait_cnt == LP_WAIT_LAST) begin
                    w_next_state = ABORT_STATE;
                    w_next_abort = 1'b1;
                end else begin
                    w_next_state = r_state;
                    w_next_cnt   = r_wait_cnt + 8'd1;
                end
            end
            M_CJUMP:     w_next_state = w_t ? w_cr_ext : w_inc;
            M_RESERVED: begin
                w_next_state  = '0;
                w_next_bad_op = 1'b1;
            end
        endcase
    end

    // State register; reset overrides hold, hold freezes everything and masks the abort pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= '0;
            r_wait_cnt  <= '0;
            r_mem_abort <= 1'b0;
            r_bad_op    <= 1'b0;
        end else if (bus.hold) begin
            r_mem_abort <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_wait_cnt  <= w_next_cnt;
            r_mem_abort <= w_next_abort;
            r_bad_op    <= w_next_bad_op;
        end
    end

    assign bus.state     = r_state;
    assign bus.mem_abort = r_mem_abort;
    assign bus.bad_op    = r_bad_op;

endmodule

// File: doc/microsequencer.md
# microsequencer

Next-state sequencer for the microprogrammed control unit. Each cycle it picks the address of the next control-ROM microinstruction from five sources: fetch (state 0), the instruction encoder's dispatch state, the microinstruction's CR field, the incremented current state, or the held current state. It selects using the N2..N0, Inv and condition inputs, which are fields of the current microinstruction. It also bounds memory waits with a MOC timeout counter, so a missing memory completion cannot hang the controller.

## Interface
- `TIMEOUT`, default 16: maximum cycles spent in a MOC-wait microinstruction before abort (2..255).
- `ABORT_STATE`, default 8'd63: microstore address entered on MOC timeout.
- `clk` input, 1 bit: clock; all state changes occur on the rising edge.
- `rst_n` input, 1 bit: reset, synchronous, active-low.
- `hold` input, 1 bit: global stall; when 1 the state and counters freeze.
- `enc_state` input, 8 bits: dispatch state from the instruction encoder.
- `cr` input, 6 bits: CR field of the current microinstruction, zero-extended to 8 bits.
- `n` input, 3 bits: {N2,N1,N0} next-state mode of the current microinstruction.
- `inv` input, 1 bit: inverts the tested condition.
- `moc` input, 1 bit: memory operation complete.
- `cond` input, 1 bit: condition-tester result, i.e. whether the ARM cond field passes the flags.
- `state` output, 8 bits: current microstore address, driven to the ROM.
- `mem_abort` output, 1 bit: one-cycle pulse on MOC timeout.
- `bad_op` output, 1 bit: sticky flag, set when reserved mode 111 is executed.

## Operation
Next-state modes, evaluated on the current `state`. Here `t = cond ^ inv` and `m = moc ^ inv`.

- 000 FETCH: next = 0.
- 001 DISPATCH: next = `enc_state`.
- 010 JUMP: next = {2'b00, cr}.
- 011 INC: next = state + 1, modulo 256 (255 -> 0).
- 100 CDISPATCH: next = `enc_state` if t, else 0. An instruction whose condition fails returns to fetch.
- 101 WAIT: if m, next = state + 1. Otherwise next = state and the wait counter increments.
- 110 CJUMP: next = {2'b00, cr} if t, else state + 1.
- 111 reserved: next = 0; `bad_op` is set.

Wait counter (8-bit):
- Cleared whenever the executed mode is not WAIT, or when WAIT completes.
- If WAIT has not completed and the counter equals TIMEOUT-1, then next = ABORT_STATE, `mem_abort` pulses for one cycle, and the counter clears.
- If m is true in the same cycle as the timeout, completion wins: no abort.

`hold` = 1:
- `state`, the counter and `bad_op` are unchanged.
- `mem_abort` is 0.
- Held cycles are not counted toward TIMEOUT.

`bad_op` is cleared only by reset.

## Timing
- Reset (`rst_n` = 0 at a rising edge): `state` = 0, wait counter = 0, `mem_abort` = 0, `bad_op` = 0. Reset overrides `hold` and takes effect mid-WAIT or mid-abort.
- One microinstruction per cycle. `n`, `inv` and `cr` are combinational functions of `state` (ROM read). `enc_state`, `moc` and `cond` must be stable before the edge. `state` updates at the edge with 1-cycle latency; there is no combinational path from inputs to `state`.
- `mem_abort` is registered. It is high in exactly the cycle where `state` == ABORT_STATE is first presented after a timeout.
- A WAIT that completes after k not-complete cycles occupies k+1 cycles, with k < TIMEOUT. A timeout occupies exactly TIMEOUT cycles in the WAIT state.
- On the cycle `rst_n` rises, the first microinstruction executed is state 0.

## Test plan
- Reset and fetch chain: assert reset with `state` = 0x2A. Then drive ROM model modes INC, INC, WAIT (moc=1 on the first cycle), DISPATCH (enc_state=0x0A). Required: state sequence 0, 1, 2, 3, 0x0A; `bad_op` = 0.
- Conditional dispatch: mode CDISPATCH, enc_state=0x05, cond=0, inv=0 -> next state 0. Repeat with cond=1 -> next 0x05. Repeat with cond=0, inv=1 -> next 0x05.
- MOC wait and timeout, TIMEOUT=16: WAIT at state 2 with moc=1 on the 5th cycle -> state 2 for 5 cycles, then 3, no abort. With moc=0 throughout -> state 2 for 16 cycles, then 63 with `mem_abort` high for exactly 1 cycle. With moc=1 on the 16th cycle -> next state 3, no abort.
- Hold during WAIT: stall 10 cycles with `hold` in the middle of a wait -> state and counter frozen; abort occurs after 16 non-held WAIT cycles.
- Jumps and wrap: JUMP with cr=0x3F -> 0x3F. CJUMP with cond=0 from state 0x10 -> 0x11. INC from 0xFF -> 0x00.
- Reserved and mid-operation reset: mode 111 -> next 0 and `bad_op` = 1, staying 1 through subsequent microinstructions. Then reset asserted during a WAIT on cycle 7 -> state 0, counter 0, `bad_op` 0; the next WAIT takes the full 16 cycles to time out.
